weight_sram_ctrl: RTL
=====================

WEIGHT_SRAM_CTRL -- requirements
Module: weight_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 18, meaning the SRAM word width.
REQ-003 SHALL have port clk, input, 1, the single clock; rising edge active.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in ADDR_W and wr_data in DATA_W, forming the write-command handshake.
REQ-006 SHALL have ports rd_req_valid in 1, rd_req_ready out 1, rd_req_addr in ADDR_W and rd_req_len in ADDR_W+1, forming the burst-read request; length is 0..16384 words.
REQ-007 SHALL have ports rd_valid out 1, rd_ready in 1, rd_data out DATA_W and rd_last out 1, forming the read-data stream.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have SRAM-side ports sram_cs, sram_web and sram_oe (out 1 each), sram_a (out ADDR_W), sram_di (out DATA_W) and sram_do (in DATA_W); the SRAM responder drives sram_do one cycle after a CS cycle.

Function
REQ-010 SHALL implement FSM states IDLE, READ and DRAIN.
- IDLE->READ on rd_req handshake with len>0.
- READ->DRAIN after the last address issues.
- DRAIN->IDLE once the last beat is accepted.
REQ-011 SHALL assert rd_req_ready only in IDLE; a request with len=0 SHALL be accepted with no beats and SHALL leave the FSM in IDLE.
REQ-012 SHALL assert wr_ready only in IDLE with rd_req_valid low, so a read request wins when both arrive together.
REQ-013 SHALL register the SRAM outputs: a write handshake at edge N drives cs=1, web=0, a=wr_addr and di=wr_data for cycle N+1, with one write per cycle sustained.
REQ-014 SHALL issue a read (cs=1, web=1) only when fifo_count + in_flight < 4; in_flight is at most 2.
REQ-015 SHALL capture sram_do in the cycle after each read issue and push it into the read FIFO.
REQ-016 SHALL increment the read address modulo 2^ADDR_W, so 16383 wraps to 0.
REQ-017 SHALL place the first rd_valid 3 cycles after the request-handshake edge when rd_ready is high.
REQ-018 SHALL sustain 1 beat per cycle under continuous rd_ready.
REQ-019 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-020 SHALL assert rd_last with the final beat of a burst only.
REQ-021 SHALL drive sram_cs=0 on every cycle with no issue.
REQ-022 SHALL drive sram_oe=1 in every cycle after reset.

Reset
REQ-023 SHALL, while rst=1, produce: state IDLE; FIFO empty; rd_valid=0; rd_last=0; busy=0; wr_ready=0; rd_req_ready=0; sram_cs=0; sram_web=1; sram_oe=0; sram_a=0; sram_di=0; rd_data=0.
REQ-024 SHALL abort any in-progress burst when reset is asserted mid-burst, emitting no further beats after release.

Configuration
REQ-025 SHALL, with WEIGHT_SRAM_PARITY_EN defined, write bit DATA_W-1 as the even parity of wr_data[DATA_W-2:0], discarding the caller's bit.
REQ-026 SHALL, with WEIGHT_SRAM_PARITY_EN defined, check each captured word and provide output parity_err, which is a sticky 1-bit flag cleared only by rst.
REQ-027 SHALL, without WEIGHT_SRAM_PARITY_EN, pass all DATA_W bits through unmodified and omit the parity_err port.

Structure
REQ-028 SHALL place ADDR_W/DATA_W defaults, the FSM state enum and the FIFO depth constant (4) in package weight_sram_pkg.
REQ-029 SHALL implement the read buffer as sub-module weight_sram_rd_fifo.
- Depth 4, DATA_W+1 wide (data plus last).
- Simultaneous push and pop SHALL be allowed when full or empty.

Verification
REQ-030 SHALL cover: writes 0x00001 to addr 5 and 0x3FFFF to addr 16383, then a burst read at addr 5 with len 1 -> one beat 0x00001 with rd_last=1, at latency 3.
REQ-031 SHALL cover: a burst at addr 16382 with len 4 -> addresses 16382, 16383, 0, 1 are issued and the beats match the prior writes.
REQ-032 SHALL cover: a len 16 burst with rd_ready toggling 1-0-0-1 -> no lost or duplicated beats, in_flight+fifo_count never exceeds 4, and rd_data is stable while stalled.
REQ-033 SHALL cover: rd_req_valid and wr_valid high in the same IDLE cycle -> the read is accepted and wr_ready=0 until back in IDLE.
REQ-034 SHALL cover: rst asserted at beat 3 of a len 8 burst -> all REQ-023 values hold immediately, with no beats after release.
REQ-035 SHALL cover, with WEIGHT_SRAM_PARITY_EN defined: forcing bit 0 of a stored word -> parity_err=1 on that beat, remaining 1 until rst.

Source files
------------

// File: rtl/weight_sram_pkg.sv
// Shared constants and FSM state type for the weight SRAM controller.
package weight_sram_pkg;

    localparam int          ADDR_W_DEF    = 14;
    localparam int          DATA_W_DEF    = 18;
    localparam int unsigned RD_FIFO_DEPTH = 4;
    localparam int          RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/weight_sram_rd_fifo.sv
// Read-return buffer: RD_FIFO_DEPTH entries of {last, data}, head visible combinationally.
module weight_sram_rd_fifo
    import weight_sram_pkg::*;
#(
    parameter int W = DATA_W_DEF + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [RD_FIFO_CNT_W-1:0] count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

    logic [W-1:0]     mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == RD_FIFO_CNT_W'(RD_FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + RD_FIFO_CNT_W'(1);
                2'b01:   count <= count - RD_FIFO_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM controller: single-cycle writes and flow-controlled burst reads.
// Define WEIGHT_SRAM_PARITY_EN to store even parity in the top data bit and expose parity_err.
module weight_sram_ctrl
    import weight_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [ADDR_W:0]   rd_req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              sram_cs,
    output logic              sram_web,
    output logic              sram_oe,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
`ifdef WEIGHT_SRAM_PARITY_EN
    output logic              parity_err,
`endif
    input  logic [DATA_W-1:0] sram_do
);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W:0]          rd_rem;
    logic                     issue_q;
    logic                     issue_last_q;
    logic                     cap_q;
    logic                     cap_last_q;
    logic                     alive_q;
    logic                     req_hs;
    logic                     wr_hs;
    logic                     can_issue;
    logic                     is_last_issue;
    logic [1:0]               in_flight;
    logic [RD_FIFO_CNT_W:0]   occupancy;
    logic [RD_FIFO_CNT_W-1:0] fifo_count;
    logic                     fifo_empty;
    logic [DATA_W:0]          fifo_head;
    logic [DATA_W-1:0]        wr_store;

`ifdef WEIGHT_SRAM_PARITY_EN
    assign wr_store = {^wr_data[DATA_W-2:0], wr_data[DATA_W-2:0]};
`else
    assign wr_store = wr_data;
`endif

    assign req_hs        = rd_req_valid && rd_req_ready;
    assign wr_hs         = wr_valid && wr_ready;
    assign in_flight     = {1'b0, issue_q} + {1'b0, cap_q};
    assign occupancy     = {1'b0, fifo_count} + {{(RD_FIFO_CNT_W-1){1'b0}}, in_flight};
    // Reads still in the SRAM pipeline count against FIFO space so no capture is ever dropped.
    assign can_issue     = (state == READ) && (occupancy < (RD_FIFO_CNT_W+1)'(RD_FIFO_DEPTH));
    assign is_last_issue = (rd_rem == (ADDR_W+1)'(1));

    assign busy     = (state != IDLE);
    assign sram_oe  = alive_q;
    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_head[DATA_W-1:0];
    assign rd_last  = !fifo_empty && fifo_head[DATA_W];

    always_comb begin
        state_nxt    = state;
        rd_req_ready = 1'b0;
        wr_ready     = 1'b0;
        case (state)
            IDLE: begin
                rd_req_ready = alive_q;
                wr_ready     = alive_q && !rd_req_valid;
                if (alive_q && rd_req_valid && (rd_req_len != '0)) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (can_issue && is_last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_valid && rd_ready && rd_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_addr      <= '0;
            rd_rem       <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            cap_q        <= 1'b0;
            cap_last_q   <= 1'b0;
            alive_q      <= 1'b0;
            sram_cs      <= 1'b0;
            sram_web     <= 1'b1;
            sram_a       <= '0;
            sram_di      <= '0;
        end else begin
            state        <= state_nxt;
            alive_q      <= 1'b1;
            issue_q      <= can_issue;
            issue_last_q <= can_issue && is_last_issue;
            cap_q        <= issue_q;
            cap_last_q   <= issue_last_q;
            if (req_hs) begin
                rd_addr <= rd_req_addr;
                rd_rem  <= rd_req_len;
            end else if (can_issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_rem  <= rd_rem - (ADDR_W+1)'(1);
            end
            sram_cs  <= wr_hs || can_issue;
            sram_web <= !wr_hs;
            if (wr_hs) begin
                sram_a  <= wr_addr;
                sram_di <= wr_store;
            end else if (can_issue) begin
                sram_a <= rd_addr;
            end
        end
    end

`ifdef WEIGHT_SRAM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (cap_q && (^sram_do)) begin
            parity_err <= 1'b1;
        end
    end
`endif

    weight_sram_rd_fifo #(
        .W (DATA_W + 1)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_q),
        .push_data ({cap_last_q, sram_do}),
        .pop       (rd_valid && rd_ready),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
